// File: rtl/tlb_pkg.sv
// Shared TLB constants, CP0 EntryHi/EntryLo field positions, entry layout and probe FSM states.
// The CP0 block uses the same field positions when it decodes these registers.
package tlb_pkg;

  localparam int TLB_ENTRIES = 16;
  localparam int TLB_INDEX_W = 4;

  localparam int HI_VPN2_HI = 31;
  localparam int HI_VPN2_LO = 13;
  localparam int HI_ASID_HI = 7;
  localparam int HI_ASID_LO = 0;

  localparam int LO_PFN_HI = 25;
  localparam int LO_PFN_LO = 6;
  localparam int LO_C_HI   = 5;
  localparam int LO_C_LO   = 3;
  localparam int LO_D      = 2;
  localparam int LO_V      = 1;
  localparam int LO_G      = 0;

  typedef logic [18:0] vpn2_t;
  typedef logic [7:0]  asid_t;
  typedef logic [19:0] pfn_t;

  typedef struct packed {
    vpn2_t      vpn2;
    asid_t      asid;
    logic       g;
    pfn_t       pfn0;
    logic [2:0] c0;
    logic       d0;
    logic       v0;
    pfn_t       pfn1;
    logic [2:0] c1;
    logic       d1;
    logic       v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    PROBE_IDLE = 2'd0,
    PROBE_SCAN = 2'd1,
    PROBE_DONE = 2'd2
  } probe_state_e;

  function automatic logic [31:0] lo_word(input pfn_t pfn, input logic [2:0] c,
                                          input logic d, input logic v, input logic g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Single-entry comparator: VPN2 must match, and either the entry is global or the ASID matches.
module tlb_match
  import tlb_pkg::*;
(
  input  vpn2_t entry_vpn2_i,
  input  asid_t entry_asid_i,
  input  logic  entry_g_i,
  input  vpn2_t vpn2_i,
  input  asid_t asid_i,
  output logic  hit_o
);

  assign hit_o = (entry_vpn2_i == vpn2_i) && (entry_g_i || (entry_asid_i == asid_i));

endmodule

// File: rtl/tlb.sv
// 16-entry joint TLB: TLBWI/TLBWR/TLBR/TLBP maintenance for CP0 plus registered address translation.
// Valid/strobe semantics: every *_wen_o and lk_valid_o is a one-cycle pulse; inputs are taken only when cpu_pause_i=0 and busy_o=0.
module tlb
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int INDEX_W = TLB_INDEX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_pause_i,
  input  logic               tlbwi_i,
  input  logic               tlbwr_i,
  input  logic               tlbr_i,
  input  logic               tlbp_i,
  input  logic [INDEX_W-1:0] cp0_index_i,
  input  logic [INDEX_W-1:0] cp0_random_i,
  input  logic [31:0]        cp0_entryhi_i,
  input  logic [31:0]        cp0_entrylo0_i,
  input  logic [31:0]        cp0_entrylo1_i,
  output logic [31:0]        cp0_entryhi_o,
  output logic [31:0]        cp0_entrylo0_o,
  output logic [31:0]        cp0_entrylo1_o,
  output logic               cp0_entryhi_wen_o,
  output logic               cp0_entrylo0_wen_o,
  output logic               cp0_entrylo1_wen_o,
  output logic [INDEX_W-1:0] cp0_index_o,
  output logic               cp0_index_wen_o,
  output logic               tlb_probe_failed_o,
  output logic               busy_o,
  output logic [1:0]         probe_state_o,
  input  logic               lk_req_i,
  input  logic [31:0]        lk_vaddr_i,
  input  logic               lk_write_i,
  input  logic               lk_user_i,
  output logic               lk_valid_o,
  output logic [31:0]        lk_paddr_o,
  output logic               exception_tlb_refill_o,
  output logic               exception_tlb_invalid_o,
  output logic               exception_tlb_mod_o,
  output logic               exception_addr_error_o,
  output logic               exception_tlb_rw_o
);

  tlb_entry_t         entries_q [ENTRIES];
  tlb_entry_t         wr_entry, lk_sel, rd_sel, scan_sel;
  probe_state_e       state_q, state_d;
  logic [INDEX_W-1:0] scan_idx_q, found_idx_q, lk_idx;
  logic               found_q, scan_hit, scan_last;
  logic               active, lk_fire, do_probe, do_read, do_wi, do_wr;
  logic [ENTRIES-1:0] lk_hits;
  logic               lk_hit, lk_odd, pg_d, pg_v, unmapped;
  pfn_t               pg_pfn;
  asid_t              hi_asid;
  logic               refill_d, invalid_d, mod_d, aerr_d;
  logic [31:0]        paddr_d;
  logic               valid_q, refill_q, invalid_q, mod_q, aerr_q, rw_q;
  logic [31:0]        paddr_q, fault_hi_q, rd_hi_q, rd_lo0_q, rd_lo1_q;
  logic               fault_wen_q, read_wen_q;
  logic               unused_bits;

  assign unused_bits = ^{cp0_entryhi_i[12:8], cp0_entrylo0_i[31:26], cp0_entrylo1_i[31:26]};
  assign hi_asid     = cp0_entryhi_i[HI_ASID_HI:HI_ASID_LO];

  // Strobe priority: tlbp > tlbr > tlbwi > tlbwr.
  assign active   = !cpu_pause_i && !busy_o;
  assign lk_fire  = active && lk_req_i;
  assign do_probe = active && tlbp_i;
  assign do_read  = active && tlbr_i && !tlbp_i;
  assign do_wi    = active && tlbwi_i && !tlbp_i && !tlbr_i;
  assign do_wr    = active && tlbwr_i && !tlbp_i && !tlbr_i && !tlbwi_i;

  always_comb begin
    wr_entry      = '0;
    wr_entry.vpn2 = cp0_entryhi_i[HI_VPN2_HI:HI_VPN2_LO];
    wr_entry.asid = hi_asid;
    wr_entry.g    = cp0_entrylo0_i[LO_G] & cp0_entrylo1_i[LO_G];
    wr_entry.pfn0 = cp0_entrylo0_i[LO_PFN_HI:LO_PFN_LO];
    wr_entry.c0   = cp0_entrylo0_i[LO_C_HI:LO_C_LO];
    wr_entry.d0   = cp0_entrylo0_i[LO_D];
    wr_entry.v0   = cp0_entrylo0_i[LO_V];
    wr_entry.pfn1 = cp0_entrylo1_i[LO_PFN_HI:LO_PFN_LO];
    wr_entry.c1   = cp0_entrylo1_i[LO_C_HI:LO_C_LO];
    wr_entry.d1   = cp0_entrylo1_i[LO_D];
    wr_entry.v1   = cp0_entrylo1_i[LO_V];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
    end else if (do_wi) begin
      entries_q[cp0_index_i] <= wr_entry;
    end else if (do_wr) begin
      entries_q[cp0_random_i] <= wr_entry;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_match
    tlb_match u_match (
      .entry_vpn2_i (entries_q[i].vpn2),
      .entry_asid_i (entries_q[i].asid),
      .entry_g_i    (entries_q[i].g),
      .vpn2_i       (lk_vaddr_i[31:13]),
      .asid_i       (hi_asid),
      .hit_o        (lk_hits[i])
    );
  end

  // Scanning downwards leaves the lowest matching index selected.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lk_hits[i]) begin
        lk_hit = 1'b1;
        lk_idx = INDEX_W'(i);
      end
    end
  end

  assign lk_sel   = entries_q[lk_idx];
  assign lk_odd   = lk_vaddr_i[12];
  assign pg_pfn   = lk_odd ? lk_sel.pfn1 : lk_sel.pfn0;
  assign pg_d     = lk_odd ? lk_sel.d1 : lk_sel.d0;
  assign pg_v     = lk_odd ? lk_sel.v1 : lk_sel.v0;
  assign unmapped = (lk_vaddr_i[31:30] == 2'b10);

  always_comb begin
    aerr_d    = lk_fire && lk_user_i && lk_vaddr_i[31];
    refill_d  = 1'b0;
    invalid_d = 1'b0;
    mod_d     = 1'b0;
    paddr_d   = '0;
    if (lk_fire && !aerr_d) begin
      if (unmapped)                  paddr_d   = {3'b000, lk_vaddr_i[28:0]};
      else if (!lk_hit)              refill_d  = 1'b1;
      else if (!pg_v)                invalid_d = 1'b1;
      else if (lk_write_i && !pg_d)  mod_d     = 1'b1;
      else                           paddr_d   = {pg_pfn, lk_vaddr_i[11:0]};
    end
  end

  assign rd_sel = entries_q[cp0_index_i];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      paddr_q     <= '0;
      refill_q    <= 1'b0;
      invalid_q   <= 1'b0;
      mod_q       <= 1'b0;
      aerr_q      <= 1'b0;
      rw_q        <= 1'b0;
      fault_wen_q <= 1'b0;
      fault_hi_q  <= '0;
      read_wen_q  <= 1'b0;
      rd_hi_q     <= '0;
      rd_lo0_q    <= '0;
      rd_lo1_q    <= '0;
    end else begin
      valid_q     <= lk_fire;
      paddr_q     <= paddr_d;
      refill_q    <= refill_d;
      invalid_q   <= invalid_d;
      mod_q       <= mod_d;
      aerr_q      <= aerr_d;
      rw_q        <= lk_write_i;
      fault_wen_q <= refill_d | invalid_d | mod_d;
      fault_hi_q  <= {lk_vaddr_i[31:13], 5'b0, hi_asid};
      read_wen_q  <= do_read;
      if (do_read) begin
        rd_hi_q  <= {rd_sel.vpn2, 5'b0, rd_sel.asid};
        rd_lo0_q <= lo_word(rd_sel.pfn0, rd_sel.c0, rd_sel.d0, rd_sel.v0, rd_sel.g);
        rd_lo1_q <= lo_word(rd_sel.pfn1, rd_sel.c1, rd_sel.d1, rd_sel.v1, rd_sel.g);
      end
    end
  end

  assign lk_valid_o              = valid_q;
  assign lk_paddr_o              = paddr_q;
  assign exception_tlb_refill_o  = refill_q;
  assign exception_tlb_invalid_o = invalid_q;
  assign exception_tlb_mod_o     = mod_q;
  assign exception_addr_error_o  = aerr_q;
  assign exception_tlb_rw_o      = rw_q;

  // TLBR readback wins over a simultaneous fault-driven EntryHi update.
  assign cp0_entryhi_wen_o  = read_wen_q | fault_wen_q;
  assign cp0_entryhi_o      = read_wen_q ? rd_hi_q : (fault_wen_q ? fault_hi_q : '0);
  assign cp0_entrylo0_wen_o = read_wen_q;
  assign cp0_entrylo1_wen_o = read_wen_q;
  assign cp0_entrylo0_o     = read_wen_q ? rd_lo0_q : '0;
  assign cp0_entrylo1_o     = read_wen_q ? rd_lo1_q : '0;

  assign scan_sel = entries_q[scan_idx_q];

  tlb_match u_probe_match (
    .entry_vpn2_i (scan_sel.vpn2),
    .entry_asid_i (scan_sel.asid),
    .entry_g_i    (scan_sel.g),
    .vpn2_i       (cp0_entryhi_i[HI_VPN2_HI:HI_VPN2_LO]),
    .asid_i       (hi_asid),
    .hit_o        (scan_hit)
  );

  assign scan_last = (scan_idx_q == INDEX_W'(ENTRIES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= PROBE_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PROBE_IDLE: if (do_probe) state_d = PROBE_SCAN;
      PROBE_SCAN: if (scan_hit || scan_last) state_d = PROBE_DONE;
      PROBE_DONE: state_d = PROBE_IDLE;
      default:    state_d = PROBE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_idx_q  <= '0;
      found_idx_q <= '0;
      found_q     <= 1'b0;
    end else if (state_q == PROBE_IDLE) begin
      scan_idx_q <= '0;
    end else if (state_q == PROBE_SCAN) begin
      if (scan_hit || scan_last) begin
        found_q     <= scan_hit;
        found_idx_q <= scan_idx_q;
      end else begin
        scan_idx_q <= scan_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy_o             = (state_q == PROBE_SCAN);
    cp0_index_wen_o    = (state_q == PROBE_DONE);
    cp0_index_o        = (state_q == PROBE_DONE && found_q) ? found_idx_q : '0;
    tlb_probe_failed_o = (state_q == PROBE_DONE) && !found_q;
    probe_state_o      = state_q;
  end

endmodule

// File: tb/tb_tlb.sv
// Directed bench for tlb: lookup vector table plus hand-written probe, readback, reset and stall sequences.
module tb_tlb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_pause_i = 1'b0;
  logic        tlbwi_i = 1'b0, tlbwr_i = 1'b0, tlbr_i = 1'b0, tlbp_i = 1'b0;
  logic [3:0]  cp0_index_i = '0, cp0_random_i = '0;
  logic [31:0] cp0_entryhi_i = '0, cp0_entrylo0_i = '0, cp0_entrylo1_i = '0;
  logic [31:0] cp0_entryhi_o, cp0_entrylo0_o, cp0_entrylo1_o;
  logic        cp0_entryhi_wen_o, cp0_entrylo0_wen_o, cp0_entrylo1_wen_o;
  logic [3:0]  cp0_index_o;
  logic        cp0_index_wen_o, tlb_probe_failed_o, busy_o;
  logic [1:0]  probe_state_o;
  logic        lk_req_i = 1'b0, lk_write_i = 1'b0, lk_user_i = 1'b0;
  logic [31:0] lk_vaddr_i = '0;
  logic        lk_valid_o;
  logic [31:0] lk_paddr_o;
  logic        exception_tlb_refill_o, exception_tlb_invalid_o, exception_tlb_mod_o;
  logic        exception_addr_error_o, exception_tlb_rw_o;

  int checks = 0;
  int failures = 0;

  tlb dut (
    .clk(clk), .reset(reset), .cpu_pause_i(cpu_pause_i),
    .tlbwi_i(tlbwi_i), .tlbwr_i(tlbwr_i), .tlbr_i(tlbr_i), .tlbp_i(tlbp_i),
    .cp0_index_i(cp0_index_i), .cp0_random_i(cp0_random_i),
    .cp0_entryhi_i(cp0_entryhi_i), .cp0_entrylo0_i(cp0_entrylo0_i), .cp0_entrylo1_i(cp0_entrylo1_i),
    .cp0_entryhi_o(cp0_entryhi_o), .cp0_entrylo0_o(cp0_entrylo0_o), .cp0_entrylo1_o(cp0_entrylo1_o),
    .cp0_entryhi_wen_o(cp0_entryhi_wen_o), .cp0_entrylo0_wen_o(cp0_entrylo0_wen_o),
    .cp0_entrylo1_wen_o(cp0_entrylo1_wen_o),
    .cp0_index_o(cp0_index_o), .cp0_index_wen_o(cp0_index_wen_o),
    .tlb_probe_failed_o(tlb_probe_failed_o), .busy_o(busy_o), .probe_state_o(probe_state_o),
    .lk_req_i(lk_req_i), .lk_vaddr_i(lk_vaddr_i), .lk_write_i(lk_write_i), .lk_user_i(lk_user_i),
    .lk_valid_o(lk_valid_o), .lk_paddr_o(lk_paddr_o),
    .exception_tlb_refill_o(exception_tlb_refill_o), .exception_tlb_invalid_o(exception_tlb_invalid_o),
    .exception_tlb_mod_o(exception_tlb_mod_o), .exception_addr_error_o(exception_addr_error_o),
    .exception_tlb_rw_o(exception_tlb_rw_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vaddr;
    logic [7:0]  asid;
    logic        wr;
    logic        user;
    logic [31:0] pa;
    logic [3:0]  flags;   // {refill, invalid, mod, addr_error}
    logic        hi_wen;
    logic [31:0] hi;
  } lk_vec_t;

  lk_vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic wi, input logic [3:0] idx, input logic [31:0] hi,
                          input logic [31:0] lo0, input logic [31:0] lo1);
    cp0_entryhi_i  = hi;
    cp0_entrylo0_i = lo0;
    cp0_entrylo1_i = lo1;
    cp0_index_i    = wi ? idx : 4'd0;
    cp0_random_i   = wi ? 4'd0 : idx;
    tlbwi_i        = wi;
    tlbwr_i        = !wi;
    tick();
    tlbwi_i = 1'b0;
    tlbwr_i = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] va, input logic [7:0] asid, input logic wr, input logic user);
    cp0_entryhi_i = {24'h0, asid};
    lk_vaddr_i    = va;
    lk_write_i    = wr;
    lk_user_i     = user;
    lk_req_i      = 1'b1;
    tick();
    lk_req_i = 1'b0;
  endtask

  task automatic run_probe(input logic [31:0] hi, output int busy_cycles, output logic seen,
                           output logic [3:0] idx, output logic failed);
    cp0_entryhi_i = hi;
    tlbp_i = 1'b1;
    tick();
    tlbp_i = 1'b0;
    busy_cycles = 0;
    seen = 1'b0;
    idx = '0;
    failed = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (cp0_index_wen_o) begin
        seen = 1'b1;
        idx = cp0_index_o;
        failed = tlb_probe_failed_o;
      end else begin
        if (busy_o) busy_cycles++;
        tick();
      end
    end
    tick();
  endtask

  initial begin
    int          bc;
    logic        seen, pf;
    logic [3:0]  pidx;
    int          wen_seen;

    vecs[0]  = '{32'h0040_0ABC, 8'h05, 1'b0, 1'b0, 32'h0004_8ABC, 4'b0000, 1'b0, 32'h0};
    vecs[1]  = '{32'h0040_0ABC, 8'h06, 1'b0, 1'b0, 32'h0,         4'b1000, 1'b1, 32'h0040_0006};
    vecs[2]  = '{32'h8000_1000, 8'h05, 1'b0, 1'b0, 32'h0000_1000, 4'b0000, 1'b0, 32'h0};
    vecs[3]  = '{32'h8000_1000, 8'h05, 1'b0, 1'b1, 32'h0,         4'b0001, 1'b0, 32'h0};
    vecs[4]  = '{32'h0080_0123, 8'h05, 1'b1, 1'b0, 32'h0,         4'b0010, 1'b1, 32'h0080_0005};
    vecs[5]  = '{32'h0080_0123, 8'h05, 1'b0, 1'b0, 32'h0001_2123, 4'b0000, 1'b0, 32'h0};
    vecs[6]  = '{32'h0080_1000, 8'h05, 1'b0, 1'b0, 32'h0,         4'b0100, 1'b1, 32'h0080_0005};
    vecs[7]  = '{32'h0100_1FFC, 8'h33, 1'b0, 1'b0, 32'h0002_2FFC, 4'b0000, 1'b0, 32'h0};
    vecs[8]  = '{32'hA000_0010, 8'h05, 1'b1, 1'b0, 32'h0000_0010, 4'b0000, 1'b0, 32'h0};
    vecs[9]  = '{32'hC000_0000, 8'h05, 1'b0, 1'b0, 32'h0,         4'b1000, 1'b1, 32'hC000_0005};
    vecs[10] = '{32'h0040_0ABC, 8'h05, 1'b0, 1'b1, 32'h0004_8ABC, 4'b0000, 1'b0, 32'h0};
    vecs[11] = '{32'h0100_0FFC, 8'h01, 1'b1, 1'b0, 32'h0001_1FFC, 4'b0000, 1'b0, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_state", 32'(probe_state_o), 32'd0);
    check("rst_valid", 32'(lk_valid_o), 32'd0);
    check("rst_wens", 32'({cp0_entryhi_wen_o, cp0_entrylo0_wen_o, cp0_entrylo1_wen_o, cp0_index_wen_o}), 32'd0);

    // Probe on an empty TLB: full scan, miss
    run_probe(32'h0040_0005, bc, seen, pidx, pf);
    check("empty_probe_done", 32'(seen), 32'd1);
    check("empty_probe_busy", 32'(bc), 32'd16);
    check("empty_probe_idx", 32'(pidx), 32'd0);
    check("empty_probe_p", 32'(pf), 32'd1);

    // Reset in the middle of a scan
    cp0_entryhi_i = 32'h0040_0005;
    tlbp_i = 1'b1;
    tick();
    tlbp_i = 1'b0;
    check("scan_busy", 32'(busy_o), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_scan_busy", 32'(busy_o), 32'd0);
    check("rst_scan_wen", 32'(cp0_index_wen_o), 32'd0);
    tick();
    reset = 1'b1;
    wen_seen = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (cp0_index_wen_o) wen_seen++;
    end
    check("rst_scan_no_wen", 32'(wen_seen), 32'd0);

    // Populate entries 3, 5 (TLBWI) and 9 (TLBWR via Random)
    do_write(1'b1, 4'd3, 32'h0040_0005, 32'h0000_1206, 32'h0);
    do_write(1'b1, 4'd5, 32'h0080_0005, 32'h0000_0482, 32'h0);
    do_write(1'b0, 4'd9, 32'h0100_0002, 32'h0000_0447, 32'h0000_0887);

    foreach (vecs[i]) begin
      lookup(vecs[i].vaddr, vecs[i].asid, vecs[i].wr, vecs[i].user);
      check($sformatf("v%0d_valid", i), 32'(lk_valid_o), 32'd1);
      check($sformatf("v%0d_flags", i),
            32'({exception_tlb_refill_o, exception_tlb_invalid_o, exception_tlb_mod_o, exception_addr_error_o}),
            32'(vecs[i].flags));
      check($sformatf("v%0d_rw", i), 32'(exception_tlb_rw_o), 32'(vecs[i].wr));
      check($sformatf("v%0d_hi_wen", i), 32'(cp0_entryhi_wen_o), 32'(vecs[i].hi_wen));
      if (vecs[i].hi_wen) check($sformatf("v%0d_hi", i), cp0_entryhi_o, vecs[i].hi);
      if (vecs[i].flags == 4'b0000) check($sformatf("v%0d_pa", i), lk_paddr_o, vecs[i].pa);
    end
    tick();
    check("valid_one_cycle", 32'(lk_valid_o), 32'd0);

    // Probe hit at index 3
    run_probe(32'h0040_0005, bc, seen, pidx, pf);
    check("hit_probe_done", 32'(seen), 32'd1);
    check("hit_probe_busy", 32'(bc), 32'd4);
    check("hit_probe_idx", 32'(pidx), 32'd3);
    check("hit_probe_p", 32'(pf), 32'd0);

    // TLBR of the Random-written entry
    cp0_index_i = 4'd9;
    tlbr_i = 1'b1;
    tick();
    tlbr_i = 1'b0;
    check("tlbr_wens", 32'({cp0_entryhi_wen_o, cp0_entrylo0_wen_o, cp0_entrylo1_wen_o}), 32'b111);
    check("tlbr_hi", cp0_entryhi_o, 32'h0100_0002);
    check("tlbr_lo0", cp0_entrylo0_o, 32'h0000_0447);
    check("tlbr_lo1", cp0_entrylo1_o, 32'h0000_0887);
    tick();
    check("tlbr_wens_drop", 32'({cp0_entryhi_wen_o, cp0_entrylo0_wen_o, cp0_entrylo1_wen_o}), 32'b000);

    // TLBR coinciding with a refill: readback data wins
    cp0_index_i = 4'd9;
    tlbr_i = 1'b1;
    lookup(32'h0040_0ABC, 8'h06, 1'b0, 1'b0);
    tlbr_i = 1'b0;
    check("tlbr_refill_flag", 32'(exception_tlb_refill_o), 32'd1);
    check("tlbr_refill_wen", 32'(cp0_entryhi_wen_o), 32'd1);
    check("tlbr_refill_hi", cp0_entryhi_o, 32'h0100_0002);

    // Everything ignored while paused
    cpu_pause_i = 1'b1;
    tlbp_i = 1'b1;
    do_write(1'b1, 4'd3, 32'h0040_0005, 32'h0000_3FC6, 32'h0);
    tlbp_i = 1'b0;
    lookup(32'h0040_0ABC, 8'h05, 1'b0, 1'b0);
    check("pause_valid", 32'(lk_valid_o), 32'd0);
    check("pause_busy", 32'(busy_o), 32'd0);
    cpu_pause_i = 1'b0;
    lookup(32'h0040_0ABC, 8'h05, 1'b0, 1'b0);
    check("pause_no_write", lk_paddr_o, 32'h0004_8ABC);

    // Writes and lookups ignored while a probe is scanning
    cp0_entryhi_i = 32'h7FFF_E005;
    tlbp_i = 1'b1;
    tick();
    tlbp_i = 1'b0;
    cp0_entrylo0_i = 32'h0000_1DC6;
    cp0_index_i = 4'd0;
    tlbwi_i = 1'b1;
    lk_vaddr_i = 32'h0040_0ABC;
    lk_req_i = 1'b1;
    tick();
    tlbwi_i = 1'b0;
    lk_req_i = 1'b0;
    check("busy_lookup_ignored", 32'(lk_valid_o), 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (cp0_index_wen_o) seen = 1'b1;
      else tick();
    end
    check("busy_probe_done", 32'(seen), 32'd1);
    tick();
    lookup(32'h7FFF_E000, 8'h05, 1'b0, 1'b0);
    check("busy_no_write", 32'(exception_tlb_refill_o), 32'd1);

    // Lowest index wins for lookup and probe
    do_write(1'b1, 4'd1, 32'h0040_0005, 32'h0000_2646, 32'h0);
    lookup(32'h0040_0ABC, 8'h05, 1'b0, 1'b0);
    check("low_idx_pa", lk_paddr_o, 32'h0009_9ABC);
    run_probe(32'h0040_0005, bc, seen, pidx, pf);
    check("low_probe_busy", 32'(bc), 32'd2);
    check("low_probe_idx", 32'(pidx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
